// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_restoring_divider_pkg;

  localparam int unsigned DW_DEF = 8;
  localparam int unsigned VW_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  // Bits needed to hold values 0..n, i.e. ceil(log2(n+1)).
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((1 << w) < (n + 1)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/seq_restoring_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// try to subtract the divisor, keep the difference when it does not borrow.
import seq_restoring_divider_pkg::*;

module div_step #(
  parameter int unsigned VW = VW_DEF
) (
  input  logic [VW:0]   i_prem,
  input  logic          i_bit,
  input  logic [VW-1:0] i_divisor,
  output logic [VW:0]   o_prem,
  output logic          o_qbit
);

  logic [VW+1:0] w_shift;
  logic [VW:0]   w_diff;

  // A non-negative trial (no borrow) is the same as shifted >= divisor; the
  // difference then always fits in VW+1 bits.
  always_comb begin
    w_shift = {i_prem, i_bit};
    w_diff  = w_shift[VW:0] - {1'b0, i_divisor};
    o_qbit  = (w_shift >= {2'b00, i_divisor});
    o_prem  = o_qbit ? w_diff : w_shift[VW:0];
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider with start/busy/done handshake,
// producing one quotient bit per clock.
import seq_restoring_divider_pkg::*;

module seq_restoring_divider #(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero
);

  localparam int unsigned CW = cnt_width(DW);
  localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  div_state_t    r_state;
  div_state_t    w_next;
  logic          w_accept;

  logic [DW-1:0] r_quo;
  logic [VW:0]   r_prem;
  logic [VW-1:0] r_div;
  logic [CW-1:0] r_cnt;

  logic [VW:0]   w_prem_next;
  logic          w_qbit;
  logic [DW-1:0] w_quo_next;

  div_step #(.VW(VW)) u_step (
    .i_prem    (r_prem),
    .i_bit     (r_quo[DW-1]),
    .i_divisor (r_div),
    .o_prem    (w_prem_next),
    .o_qbit    (w_qbit)
  );

  assign w_quo_next = {r_quo[DW-2:0], w_qbit};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_next   = r_state;
    busy     = 1'b0;
    done     = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = start;
        if (start) w_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (r_div == '0 || r_cnt == LAST_STEP) w_next = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        w_accept = start;
        w_next   = start ? S_RUN : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand load, one restoring step per RUN cycle, result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_quo     <= '0;
      r_prem    <= '0;
      r_div     <= '0;
      r_cnt     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else if (w_accept) begin
      r_quo     <= dividend;
      r_prem    <= '0;
      r_div     <= divisor;
      r_cnt     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else if (r_state == S_RUN) begin
      if (r_div == '0) begin
        quotient  <= '1;
        remainder <= '0;
        div_zero  <= 1'b1;
      end else begin
        r_quo  <= w_quo_next;
        r_prem <= w_prem_next;
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
        if (r_cnt == LAST_STEP) begin
          quotient  <= w_quo_next;
          remainder <= w_prem_next[VW-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_zero;

  int n_checks = 0;
  int n_fail   = 0;

  seq_restoring_divider #(.DW(8), .VW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Drive a start pulse for one cycle; returns at the negedge of busy cycle 1.
  task automatic issue(input logic [7:0] dd, input logic [3:0] dv);
    @(negedge clk);
    start = 1'b1; dividend = dd; divisor = dv;
    @(negedge clk);
    start = 1'b0;
  endtask

  // From the current negedge, count remaining busy cycles, then check the
  // done cycle against plain arithmetic. Returns at the done-cycle negedge.
  task automatic collect(input logic [7:0] dd, input logic [3:0] dv,
                         input int exp_busy, input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      if (n == 0) chk({tag, ".q_busy"}, quotient, 0);
      n++;
      @(negedge clk);
    end
    chk({tag, ".busy_cycles"}, n, exp_busy);
    chk({tag, ".done"}, done, 1);
    chk({tag, ".quot"}, quotient, (dv == 0) ? 8'd255 : 8'(dd / dv));
    chk({tag, ".rem"},  remainder, (dv == 0) ? 4'd0 : 4'(dd % dv));
    chk({tag, ".dz"},   div_zero, (dv == 0) ? 1 : 0);
  endtask

  task automatic run_div(input logic [7:0] dd, input logic [3:0] dv, input string tag);
    issue(dd, dv);
    collect(dd, dv, (dv == 0) ? 1 : 8, tag);
    @(negedge clk);
    chk({tag, ".done_fall"}, done, 0);
    chk({tag, ".q_hold"}, quotient, (dv == 0) ? 8'd255 : 8'(dd / dv));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.quot", quotient, 0);
    chk("rst.rem",  remainder, 0);
    chk("rst.dz",   div_zero, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle.busy", busy, 0);

    // Directed cases
    run_div(8'd143, 4'd11, "d143_11");
    run_div(8'd100, 4'd7,  "d100_7");
    run_div(8'd7,   4'd15, "d7_15");
    run_div(8'd255, 4'd1,  "d255_1");
    run_div(8'd200, 4'd0,  "d200_0");

    // Start while busy is ignored; start in done cycle is accepted
    issue(8'd143, 4'd11);
    repeat (2) @(negedge clk);
    start = 1'b1; dividend = 8'd225; divisor = 4'd15;
    @(negedge clk);
    start = 1'b0;
    collect(8'd143, 4'd11, 5, "ign");
    start = 1'b1; dividend = 8'd225; divisor = 4'd15;
    @(negedge clk);
    start = 1'b0;
    chk("b2b.busy", busy, 1);
    chk("b2b.done", done, 0);
    chk("b2b.quot", quotient, 0);
    collect(8'd225, 4'd15, 8, "b2b");
    @(negedge clk);

    // Asynchronous reset mid-operation
    issue(8'd100, 4'd7);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst.busy", busy, 0);
    chk("arst.done", done, 0);
    chk("arst.quot", quotient, 0);
    chk("arst.rem",  remainder, 0);
    chk("arst.dz",   div_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (12) begin
        @(negedge clk);
        if (done === 1'b1 || busy === 1'b1) seen++;
      end
      chk("arst.no_done", seen, 0);
    end

    // Exhaustive sweep, with random idle gaps between operations
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        repeat ($urandom_range(0, 1)) @(negedge clk);
        run_div(8'(a), 4'(b), "sweep");
      end
    end

    // Random back-to-back chains started in the done cycle
    begin
      logic [7:0] dd;
      logic [3:0] dv;
      dd = 8'($urandom); dv = 4'($urandom);
      issue(dd, dv);
      for (int i = 0; i < 100; i++) begin
        logic [7:0] nd;
        logic [3:0] nv;
        collect(dd, dv, (dv == 0) ? 1 : 8, "rnd");
        nd = 8'($urandom); nv = 4'($urandom_range(0, 15));
        start = 1'b1; dividend = nd; divisor = nv;
        @(negedge clk);
        start = 1'b0;
        dd = nd; dv = nv;
      end
      collect(dd, dv, (dv == 0) ? 1 : 8, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Iterative unsigned restoring divider; the inverse operation of the 4x4 array multiplier block.
- Takes an 8-bit dividend (multiplier product width) and a 4-bit divisor (multiplier operand width).
- Produces quotient and remainder, one quotient bit per clock.
- Sits behind the Tiny Tapeout top-level wrapper with a start/busy/done handshake so a host can recover operands from a product.

Parameters:
DW, 8, dividend and quotient width
VW, 4, divisor and remainder width

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a division; sampled only when busy=0
dividend  input  DW  unsigned dividend, sampled with an accepted start
divisor  input  VW  unsigned divisor, sampled with an accepted start
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse; results valid from this cycle
quotient  output  DW  unsigned quotient, held until the next accepted start
remainder  output  VW  unsigned remainder, held until the next accepted start
div_zero  output  1  set with done when divisor was 0; held with results

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset (asynchronous assert, any time including mid-operation):
  - FSM goes to IDLE.
  - busy, done, div_zero, quotient and remainder all go to 0.
  - Internal counter, partial remainder and operand registers clear.
  - No result from the aborted operation is ever presented.
- FSM states and transitions:
  - IDLE -> RUN on accepted start.
  - RUN -> DONE after the last step.
  - DONE -> IDLE after one cycle, or DONE -> RUN if start is accepted in DONE.
- Start acceptance:
  - start is accepted when start=1 and busy=0, i.e. in IDLE or DONE.
  - start while busy=1 is ignored, and the operation in flight is unaffected.
- Latency, with acceptance at edge k:
  - Edge k: operands load; the working quotient register is preloaded with the dividend, the partial remainder (VW+1 bits) is cleared, and busy=1.
  - Edges k+1..k+DW: one restoring step per edge.
  - Each step shifts {partial remainder, working quotient} left by 1.
  - It then computes trial = partial remainder - {0,divisor}.
  - If trial is non-negative (borrow=0): partial remainder <= trial and the new quotient LSB = 1.
  - Otherwise the partial remainder is kept and the new quotient LSB = 0.
  - At edge k+DW the state moves to DONE: busy=0, done=1, and quotient/remainder are updated.
  - Total: busy high for DW cycles, done high for exactly one cycle.
- Divide by zero (divisor=0 at acceptance):
  - Edge k: busy=1 for one cycle; no iterations run.
  - Edge k+1: DONE, done=1, div_zero=1, quotient=all ones, remainder=0.
- Outputs quotient, remainder and div_zero:
  - They hold their values through IDLE.
  - They are cleared to 0 at the next accepted start, and stay 0 while busy.
- Back-to-back: start asserted during the DONE cycle is accepted at that edge. done falls and busy rises on the same edge.
- Arithmetic: unsigned only, with no overflow possible.
  - quotient*divisor + remainder = dividend.
  - remainder < divisor.
- The iteration counter is ceil(log2(DW+1)) bits and saturates; it never wraps.

Decomposition:
- Shared package: FSM state enum (IDLE, RUN, DONE), DW/VW default constants, and the counter width function.
- One sub-module, div_step: a combinational single restoring step.
  - Inputs: partial remainder VW+1, incoming bit, divisor.
  - Outputs: next partial remainder, quotient bit.
  - It is instantiated once and reused each cycle; no unrolling.

Test Plan:
- Dividend 143, divisor 11, start one cycle -> busy high 8 cycles; done pulses once; quotient 13, remainder 0, div_zero 0.
- Dividend 100, divisor 7 -> quotient 14, remainder 2. Dividend 7, divisor 15 -> quotient 0, remainder 7. Dividend 255, divisor 1 -> quotient 255, remainder 0.
- Dividend 200, divisor 0 -> busy 1 cycle, then done with div_zero 1, quotient 255, remainder 0.
- Start 143/11; pulse start with 225/15 at cycle 3 of busy -> ignored; result 13 r 0. Then start 225/15 in the done cycle -> accepted; 8 cycles later quotient 15, remainder 0.
- Start 100/7; assert rst at busy cycle 4 -> all outputs 0 immediately (asynchronous); after release no done pulse until a new start.
- Exhaustive sweep of all 256x16 operand pairs, with a reference model checking quotient, remainder, div_zero and exact done timing.
